// File: rtl/mlp_inference_scheduler.sv
// mlp_inference_scheduler: queues input feature vectors in a small FIFO and runs them through the
// MLP one at a time. Each launch is a one-cycle start pulse. mlp_x is held until mlp_done, then the
// scores are captured and their argmax is presented on a valid/ready result slot.
// Optional feature macro: SCHED_TIMEOUT_EN adds a watchdog on the WAIT state. On timeout it emits a
// result with out_err=1 and zeroed scores.
module mlp_inference_scheduler #(
  parameter int unsigned NUM_FEATURES   = 4,
  parameter int unsigned NUM_CLASSES    = 3,
  parameter int unsigned FP_TOTAL_BITS  = 16,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TAG_BITS       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [NUM_FEATURES-1:0][FP_TOTAL_BITS-1:0]    in_x,
  output logic                                          mlp_start,
  output logic [NUM_FEATURES-1:0][FP_TOTAL_BITS-1:0]    mlp_x,
  input  logic [NUM_CLASSES-1:0][FP_TOTAL_BITS-1:0]     mlp_out,
  input  logic                                          mlp_done,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [NUM_CLASSES-1:0][FP_TOTAL_BITS-1:0]     out_scores,
  output logic [$clog2(NUM_CLASSES)-1:0]                out_class,
  output logic [TAG_BITS-1:0]                           out_tag,
  output logic                                          out_err,
  output logic                                          busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CLS_W = $clog2(NUM_CLASSES);

  // Reject configurations the pointer arithmetic and watchdog cannot support.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1)
  begin : g_param_check
    $error("mlp_inference_scheduler: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
  end

  typedef logic [NUM_FEATURES-1:0][FP_TOTAL_BITS-1:0] feat_t;
  typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

  state_e                 state;
  feat_t                  fifo_x   [FIFO_DEPTH];
  logic [TAG_BITS-1:0]    fifo_tag [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [PTR_W:0]         count;
  logic [TAG_BITS-1:0]    tag_ctr;
  logic [TAG_BITS-1:0]    cur_tag;
  logic                   push, pop, fifo_empty, slot_free;
  logic [CLS_W-1:0]       best_idx;
  logic signed [FP_TOTAL_BITS-1:0] best_val;

  assign fifo_empty = (count == '0);
  // in_ready is based on registered occupancy only, so a same-cycle pop never frees a full queue.
  assign in_ready   = (count != (PTR_W + 1)'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  // The result slot is free if it is empty or is being consumed at this edge.
  assign slot_free  = !out_valid || out_ready;
  assign pop        = (state == StIdle) && !fifo_empty && slot_free;
  assign busy       = (state != StIdle) || !fifo_empty;

  // Sample storage. Entries are read only after they are written, so they need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_x[wr_ptr]   <= in_x;
      fifo_tag[wr_ptr] <= tag_ctr;
    end
  end

  // Queue pointers, occupancy and the per-sample sequence tag counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tag_ctr <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        tag_ctr <= tag_ctr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Signed argmax over the live MLP scores. A strict compare keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_val = mlp_out[0];
    for (int unsigned c = 1; c < NUM_CLASSES; c++) begin
      if ($signed(mlp_out[c]) > best_val) begin
        best_val = mlp_out[c];
        best_idx = CLS_W'(c);
      end
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;
`else
  assign out_err = 1'b0;
`endif

  // Launch/wait sequencer with registered start pulse and result slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= StIdle;
      mlp_start  <= 1'b0;
      mlp_x      <= '0;
      cur_tag    <= '0;
      out_valid  <= 1'b0;
      out_scores <= '0;
      out_class  <= '0;
      out_tag    <= '0;
`ifdef SCHED_TIMEOUT_EN
      out_err    <= 1'b0;
      wd_cnt     <= '0;
`endif
    end else begin
      mlp_start <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        StIdle: begin
          if (pop) begin
            mlp_x     <= fifo_x[rd_ptr];
            cur_tag   <= fifo_tag[rd_ptr];
            mlp_start <= 1'b1;
            state     <= StLaunch;
          end
        end
        StLaunch: begin
          state <= StWait;
`ifdef SCHED_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        StWait: begin
          // A launch only happens with a free slot, so this capture never overwrites a result.
          if (mlp_done) begin
            out_valid  <= 1'b1;
            out_scores <= mlp_out;
            out_class  <= best_idx;
            out_tag    <= cur_tag;
`ifdef SCHED_TIMEOUT_EN
            out_err    <= 1'b0;
`endif
            state      <= StIdle;
          end
`ifdef SCHED_TIMEOUT_EN
          else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            out_valid  <= 1'b1;
            out_scores <= '0;
            out_class  <= '0;
            out_tag    <= cur_tag;
            out_err    <= 1'b1;
            state      <= StIdle;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_inference_scheduler.sv
// Self-checking bench for mlp_inference_scheduler. It uses a table of argmax vectors and directed
// corner sequences. A randomized phase is checked against a queue-based reference model.
module tb_mlp_inference_scheduler;

  localparam int NF    = 4;
  localparam int NC    = 3;
  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int TAGB  = 4;

  typedef logic [NF-1:0][W-1:0] feat_t;
  typedef logic [NC-1:0][W-1:0] score_t;
  typedef struct { feat_t x; score_t scores; int cls; } vec_t;
  typedef struct { feat_t x; score_t scores; int cls; int tag; bit err; bit never; } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic mlp_done = 1'b0;
  feat_t in_x = '0;
  score_t mlp_out = '0;
  logic in_ready, mlp_start, out_valid, out_err, busy;
  feat_t mlp_x;
  score_t out_scores;
  logic [1:0] out_class;
  logic [TAGB-1:0] out_tag;

  mlp_inference_scheduler #(
    .NUM_FEATURES(NF), .NUM_CLASSES(NC), .FP_TOTAL_BITS(W), .FIFO_DEPTH(DEPTH),
    .TAG_BITS(TAGB), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .mlp_start(mlp_start), .mlp_x(mlp_x), .mlp_out(mlp_out), .mlp_done(mlp_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_scores(out_scores),
    .out_class(out_class), .out_tag(out_tag), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: samples awaiting launch, results awaiting consumption.
  exp_t launch_q[$];
  exp_t res_q[$];
  int tag_ctr = 0, occ = 0, cyc = 0, starts = 0, acc_total = 0, last_tag = -1;
  int last_start_cyc = -1;
  bit prev_acc = 0, prev_start = 0, prev_done = 0;
  // Mock MLP.
  exp_t mock_cur;
  bit mock_busy = 0, mock_chk = 0;
  int mock_cnt = 0, mock_lat = 5;
  bit rand_lat = 0;
  // Stimulus modes.
  bit fixed_en = 0, never_done = 0;
  score_t fixed_scores = '0;
  int fixed_cls = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic feat_t mk_x(input logic [W-1:0] a, b, c, d);
    feat_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  function automatic score_t mk_s(input logic [W-1:0] a, b, c);
    score_t r;
    r[0] = a; r[1] = b; r[2] = c;
    return r;
  endfunction

  function automatic feat_t rand_x();
    feat_t r;
    for (int f = 0; f < NF; f++) r[f] = W'($urandom);
    return r;
  endfunction

  function automatic score_t rand_s();
    score_t r;
    for (int c = 0; c < NC; c++) r[c] = W'($urandom);
    return r;
  endfunction

  // Arbitrary deterministic stand-in for the MLP datapath.
  function automatic score_t model_scores(input feat_t x);
    score_t s;
    for (int c = 0; c < NC; c++) s[c] = W'(int'(x[c]) + 2 * int'(x[(c + 1) % NF]) + 3 * c);
    return s;
  endfunction

  function automatic int ref_argmax(input score_t s);
    int best = 0;
    for (int c = 1; c < NC; c++) if ($signed(s[c]) > $signed(s[best])) best = c;
    return best;
  endfunction

  task automatic clear_model();
    launch_q.delete();
    res_q.delete();
    tag_ctr = 0; occ = 0;
    prev_acc = 0; prev_start = 0; prev_done = 0;
    mock_chk = 0;
  endtask

  // One clock cycle: model the previous edge, run the mock MLP, drive inputs, score results.
  task automatic step(input bit v, input feat_t x, input bit rdy);
    exp_t e;
    @(negedge clk);
    cyc++;
    if (prev_done) check("valid_after_done", {63'd0, out_valid}, 64'd1);
    prev_done = 0;
    mlp_done = 1'b0;
    mlp_out = rand_s();
    if (prev_acc) occ++;
    if (mlp_start) begin
      starts++;
      last_start_cyc = cyc;
      occ--;
      check("start_single_cycle", {63'd0, prev_start}, 64'd0);
      if (launch_q.size() == 0) begin
        check("unexpected_start", {63'd0, mlp_start}, 64'd0);
      end else begin
        mock_cur = launch_q.pop_front();
        check("mlp_x_at_start", mlp_x, mock_cur.x);
        mock_chk = 1;
        mock_busy = !mock_cur.never;
        mock_cnt = rand_lat ? int'($urandom_range(8, 1)) : mock_lat;
      end
    end else if (mock_busy) begin
      if (mock_chk) check("mlp_x_hold", mlp_x, mock_cur.x);
      mock_cnt--;
      if (mock_cnt == 0) begin
        mlp_done = 1'b1;
        mlp_out = mock_cur.scores;
        mock_busy = 0;
        prev_done = mock_chk;
      end
    end
    check("in_ready", {63'd0, in_ready}, {63'd0, (occ < DEPTH)});
    prev_start = mlp_start;
    in_valid = v; in_x = x; out_ready = rdy;
    prev_acc = v && in_ready;
    if (prev_acc) begin
      e.x = x;
      e.never = never_done;
      e.err = never_done;
      e.tag = tag_ctr % (1 << TAGB);
      tag_ctr++;
      acc_total++;
      if (never_done) begin
        e.scores = '0; e.cls = 0;
      end else if (fixed_en) begin
        e.scores = fixed_scores; e.cls = fixed_cls;
      end else begin
        e.scores = model_scores(x); e.cls = ref_argmax(e.scores);
      end
      launch_q.push_back(e);
      res_q.push_back(e);
    end
    if (out_valid && rdy) begin
      if (res_q.size() == 0) begin
        check("unexpected_result", {63'd0, out_valid}, 64'd0);
      end else begin
        e = res_q.pop_front();
        check("out_scores", out_scores, e.scores);
        check("out_class", out_class, e.cls);
        check("out_tag", out_tag, e.tag);
        check("out_err", {63'd0, out_err}, {63'd0, e.err});
        last_tag = int'(out_tag);
      end
    end
  endtask

  task automatic drain(input int budget, input bit rand_rdy);
    int n = 0;
    while ((res_q.size() != 0 || mock_busy) && n < budget) begin
      step(0, '0, rand_rdy ? ($urandom_range(1, 0) == 1) : 1'b1);
      n++;
    end
    check("drain_done", res_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mlp_start", {63'd0, mlp_start}, 64'd0);
    check("rst_out_err", {63'd0, out_err}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_mlp_x", mlp_x, 64'd0);
    check("rst_out_scores", out_scores, 64'd0);
    check("rst_out_class", out_class, 64'd0);
    check("rst_out_tag", out_tag, 64'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mlp_done = 1'b0;
    clear_model();
    mock_busy = 0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    vec_t tbl[6];
    int s0, n, a_cyc;
    tbl[0] = '{x: mk_x(16'h0100, 16'h0200, 16'h0000, 16'hFF00),
               scores: mk_s(16'h0100, 16'h0300, 16'h0300), cls: 1};
    tbl[1] = '{x: mk_x(16'h1234, 16'h8001, 16'h7FFF, 16'h0042),
               scores: mk_s(16'hFE00, 16'hFF00, 16'hFF80), cls: 2};
    tbl[2] = '{x: mk_x(16'h0001, 16'h0002, 16'h0003, 16'h0004),
               scores: mk_s(16'h0005, 16'h0005, 16'h0005), cls: 0};
    tbl[3] = '{x: mk_x(16'hFFFF, 16'h0000, 16'hAAAA, 16'h5555),
               scores: mk_s(16'h8000, 16'h7FFF, 16'h0000), cls: 1};
    tbl[4] = '{x: mk_x(16'h00FF, 16'hFF00, 16'h0F0F, 16'hF0F0),
               scores: mk_s(16'hFFFF, 16'h0000, 16'h0001), cls: 2};
    tbl[5] = '{x: mk_x(16'h7FFF, 16'h8000, 16'h0001, 16'hFFFE),
               scores: mk_s(16'h7FFF, 16'h8000, 16'h7FFF), cls: 0};

    // Reset state, then table-driven argmax vectors with start-latency checks.
    apply_reset();
    fixed_en = 1; mock_lat = 5;
    for (int i = 0; i < 6; i++) begin
      fixed_scores = tbl[i].scores;
      fixed_cls = tbl[i].cls;
      step(1, tbl[i].x, 1);
      step(0, '0, 1);
      check("start_not_yet", {63'd0, mlp_start}, 64'd0);
      step(0, '0, 1);
      check("start_2nd_cycle", {63'd0, mlp_start}, 64'd1);
      drain(40, 0);
    end
    fixed_en = 0;

    // Back-pressure: five samples with out_ready low; only one result may be held.
    apply_reset();
    mock_lat = 3; s0 = starts; n = 0; acc_total = 0;
    while (acc_total < 5 && n < 20) begin
      step(1, rand_x(), 0);
      n++;
    end
    repeat (15) step(0, '0, 0);
    check("bp_one_start", starts - s0, 1);
    check("bp_out_valid", {63'd0, out_valid}, 64'd1);
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    drain(100, 0);
    check("bp_last_tag", last_tag, 4);

    // Tag wrap: the 17th result after reset carries tag 0.
    apply_reset();
    mock_lat = 2; n = 0; acc_total = 0;
    while (acc_total < 17 && n < 300) begin
      step(acc_total < 17, rand_x(), 1);
      n++;
    end
    drain(200, 0);
    check("wrap_last_tag", last_tag, 0);

    // Reset during WAIT with two samples queued; the late mlp_done must be ignored.
    apply_reset();
    mock_lat = 20; n = 0; acc_total = 0;
    while (acc_total < 3 && n < 10) begin
      step(1, rand_x(), 1);
      n++;
    end
    repeat (3) step(0, '0, 1);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_outputs();
    clear_model();
    @(negedge clk);
    reset = 1'b1;
    s0 = starts;
    for (int i = 0; i < 30; i++) begin
      step(0, '0, 1);
      check("post_rst_no_result", {63'd0, out_valid}, 64'd0);
    end
    check("post_rst_no_start", starts - s0, 0);
    check("post_rst_busy", {63'd0, busy}, 64'd0);

`ifdef SCHED_TIMEOUT_EN
    // Watchdog: a launch that never completes yields an error result 64 cycles into WAIT.
    apply_reset();
    mock_lat = 4; s0 = starts;
    never_done = 1;
    step(1, rand_x(), 1);
    a_cyc = cyc;
    never_done = 0;
    step(1, rand_x(), 1);
    step(0, '0, 1);
    check("to_start_cycle", last_start_cyc, a_cyc + 2);
    n = 0;
    while (cyc < a_cyc + 2 + 64 && n < 100) begin
      step(0, '0, 1);
      n++;
    end
    check("to_not_early", {63'd0, out_valid}, 64'd0);
    step(0, '0, 1);
    check("to_valid", {63'd0, out_valid}, 64'd1);
    check("to_err", {63'd0, out_err}, 64'd1);
    drain(100, 0);
    check("to_next_launch", starts - s0, 2);
`else
    a_cyc = 0;
`endif

    // Randomized traffic against the reference model.
    apply_reset();
    rand_lat = 1;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(2, 0) != 0, rand_x(), $urandom_range(3, 0) != 0);
    end
    drain(400, 1);
    step(0, '0, 1);
    check("final_idle", {63'd0, busy}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
